// File: rtl/rgb2hsv_stream.sv
// Pipelined RGB to HSV converter: one pixel per clock, latency DW+4.
// Define RGB2HSV_STREAM_SAT_EN to build the saturation divider (s = 0 otherwise).
module rgb2hsv_stream #(
  parameter int DW = 8,
  parameter int TW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] r,
  input  logic [DW-1:0] g,
  input  logic [DW-1:0] b,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  output logic [DW-1:0] h,
  output logic [DW-1:0] s,
  output logic [DW-1:0] v,
  output logic [TW-1:0] out_tag,
  output logic          hue_valid
);

  localparam int PW = 2*DW + 3;
  localparam logic [PW-1:0] MAXW = PW'((1 << DW) - 1);
  localparam logic [DW-1:0] OFF  = DW'(((1 << DW) - 1) / 3);
  localparam logic [DW-1:0] OFF2 = DW'(2 * (((1 << DW) - 1) / 3));

  // stage 1: input registers
  logic          vld1_d, vld1_q;
  logic [TW-1:0] tag1_d, tag1_q;
  logic [DW-1:0] r1_d, r1_q, g1_d, g1_q, b1_d, b1_q;

  // stage 2: max / min / delta / sector
  logic          vld2_d, vld2_q;
  logic [TW-1:0] tag2_d, tag2_q;
  logic [DW-1:0] mx2_d, mx2_q, dl2_d, dl2_q, ad2_d, ad2_q;
  logic          neg2_d, neg2_q;
  logic [1:0]    sec2_d, sec2_q;
  logic [DW-1:0] mx_c, mn_c, dp_c, dn_c;

  // stage 3 (index 0) and divider stages (index 1..DW)
  logic [PW-1:0] hrem_d [0:DW];
  logic [PW-1:0] hrem_q [0:DW];
  logic [PW-1:0] hden_d [0:DW];
  logic [PW-1:0] hden_q [0:DW];
  logic [DW-1:0] hquo_d [0:DW];
  logic [DW-1:0] hquo_q [0:DW];
`ifdef RGB2HSV_STREAM_SAT_EN
  logic [PW-1:0] srem_d [0:DW];
  logic [PW-1:0] srem_q [0:DW];
  logic [PW-1:0] sden_d [0:DW];
  logic [PW-1:0] sden_q [0:DW];
  logic [DW-1:0] squo_d [0:DW];
  logic [DW-1:0] squo_q [0:DW];
`endif
  logic          vld_d [0:DW];
  logic          vld_q [0:DW];
  logic [TW-1:0] tag_d [0:DW];
  logic [TW-1:0] tag_q [0:DW];
  logic [DW-1:0] mx_d  [0:DW];
  logic [DW-1:0] mx_q  [0:DW];
  logic          neg_d [0:DW];
  logic          neg_q [0:DW];
  logic [1:0]    sec_d [0:DW];
  logic [1:0]    sec_q [0:DW];
  logic          hv_d  [0:DW];
  logic          hv_q  [0:DW];

  // hue stage and output registers
  logic          hvld_d, hvld_q, hhv_d, hhv_q;
  logic [TW-1:0] htag_d, htag_q;
  logic [DW-1:0] hh_d, hh_q, hs_d, hs_q, hvv_d, hvv_q;
  logic [DW-1:0] base_c;
  logic          ov_d, ov_q, ohv_d, ohv_q;
  logic [TW-1:0] otag_d, otag_q;
  logic [DW-1:0] oh_d, oh_q, os_d, os_q, ovv_d, ovv_q;

  always_comb begin
    vld1_d = in_valid;
    tag1_d = in_tag;
    r1_d   = r;
    g1_d   = g;
    b1_d   = b;
  end

  always_comb begin
    sec2_d = 2'd2;
    dp_c   = r1_q;
    dn_c   = g1_q;
    if (r1_q >= g1_q && r1_q >= b1_q) begin
      sec2_d = 2'd0;
      dp_c   = g1_q;
      dn_c   = b1_q;
    end else if (g1_q >= b1_q) begin
      sec2_d = 2'd1;
      dp_c   = b1_q;
      dn_c   = r1_q;
    end
    mx_c = r1_q;
    if (g1_q > mx_c) mx_c = g1_q;
    if (b1_q > mx_c) mx_c = b1_q;
    mn_c = r1_q;
    if (g1_q < mn_c) mn_c = g1_q;
    if (b1_q < mn_c) mn_c = b1_q;
    mx2_d  = mx_c;
    dl2_d  = mx_c - mn_c;
    neg2_d = dp_c < dn_c;
    ad2_d  = neg2_d ? dn_c - dp_c : dp_c - dn_c;
    vld2_d = vld1_q;
    tag2_d = tag1_q;
  end

  // restoring division: quotient bit DW-1-k resolved in stage k
  always_comb begin
    logic [PW-1:0] hsh;
`ifdef RGB2HSV_STREAM_SAT_EN
    logic [PW-1:0] ssh;
    srem_d[0] = MAXW * PW'(dl2_q);
    sden_d[0] = PW'(mx2_q);
    squo_d[0] = '0;
`endif
    hrem_d[0] = MAXW * PW'(ad2_q);
    hden_d[0] = PW'(dl2_q) * PW'(3'd6);
    hquo_d[0] = '0;
    vld_d[0]  = vld2_q;
    tag_d[0]  = tag2_q;
    mx_d[0]   = mx2_q;
    neg_d[0]  = neg2_q;
    sec_d[0]  = sec2_q;
    hv_d[0]   = dl2_q != '0;
    for (int k = 0; k < DW; k++) begin
      hsh = hden_q[k] << (DW - 1 - k);
      hrem_d[k+1] = hrem_q[k];
      hden_d[k+1] = hden_q[k];
      hquo_d[k+1] = hquo_q[k];
      if (hrem_q[k] >= hsh) begin
        hrem_d[k+1] = hrem_q[k] - hsh;
        hquo_d[k+1][DW-1-k] = 1'b1;
      end
`ifdef RGB2HSV_STREAM_SAT_EN
      ssh = sden_q[k] << (DW - 1 - k);
      srem_d[k+1] = srem_q[k];
      sden_d[k+1] = sden_q[k];
      squo_d[k+1] = squo_q[k];
      if (srem_q[k] >= ssh) begin
        srem_d[k+1] = srem_q[k] - ssh;
        squo_d[k+1][DW-1-k] = 1'b1;
      end
`endif
      vld_d[k+1] = vld_q[k];
      tag_d[k+1] = tag_q[k];
      mx_d[k+1]  = mx_q[k];
      neg_d[k+1] = neg_q[k];
      sec_d[k+1] = sec_q[k];
      hv_d[k+1]  = hv_q[k];
    end
  end

  always_comb begin
    case (sec_q[DW])
      2'd0:    base_c = '0;
      2'd1:    base_c = OFF;
      default: base_c = OFF2;
    endcase
    hh_d = neg_q[DW] ? base_c - hquo_q[DW] : base_c + hquo_q[DW];
`ifdef RGB2HSV_STREAM_SAT_EN
    hs_d = squo_q[DW];
`else
    hs_d = '0;
`endif
    if (!hv_q[DW]) begin
      hh_d = '0;
      hs_d = '0;
    end
    hvv_d  = mx_q[DW];
    hhv_d  = hv_q[DW];
    htag_d = tag_q[DW];
    hvld_d = vld_q[DW];
  end

  // outputs hold between valid pixels
  always_comb begin
    ov_d   = hvld_q;
    oh_d   = hvld_q ? hh_q   : oh_q;
    os_d   = hvld_q ? hs_q   : os_q;
    ovv_d  = hvld_q ? hvv_q  : ovv_q;
    otag_d = hvld_q ? htag_q : otag_q;
    ohv_d  = hvld_q ? hhv_q  : ohv_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld1_d_reset: begin
        vld1_q <= 1'b0;
        tag1_q <= '0;
        r1_q   <= '0;
        g1_q   <= '0;
        b1_q   <= '0;
      end
      vld2_q <= 1'b0;
      tag2_q <= '0;
      mx2_q  <= '0;
      dl2_q  <= '0;
      ad2_q  <= '0;
      neg2_q <= 1'b0;
      sec2_q <= '0;
      for (int k = 0; k <= DW; k++) begin
        hrem_q[k] <= '0;
        hden_q[k] <= '0;
        hquo_q[k] <= '0;
`ifdef RGB2HSV_STREAM_SAT_EN
        srem_q[k] <= '0;
        sden_q[k] <= '0;
        squo_q[k] <= '0;
`endif
        vld_q[k]  <= 1'b0;
        tag_q[k]  <= '0;
        mx_q[k]   <= '0;
        neg_q[k]  <= 1'b0;
        sec_q[k]  <= '0;
        hv_q[k]   <= 1'b0;
      end
      hvld_q <= 1'b0;
      hhv_q  <= 1'b0;
      htag_q <= '0;
      hh_q   <= '0;
      hs_q   <= '0;
      hvv_q  <= '0;
      ov_q   <= 1'b0;
      ohv_q  <= 1'b0;
      otag_q <= '0;
      oh_q   <= '0;
      os_q   <= '0;
      ovv_q  <= '0;
    end else begin
      vld1_q <= vld1_d;
      tag1_q <= tag1_d;
      r1_q   <= r1_d;
      g1_q   <= g1_d;
      b1_q   <= b1_d;
      vld2_q <= vld2_d;
      tag2_q <= tag2_d;
      mx2_q  <= mx2_d;
      dl2_q  <= dl2_d;
      ad2_q  <= ad2_d;
      neg2_q <= neg2_d;
      sec2_q <= sec2_d;
      for (int k = 0; k <= DW; k++) begin
        hrem_q[k] <= hrem_d[k];
        hden_q[k] <= hden_d[k];
        hquo_q[k] <= hquo_d[k];
`ifdef RGB2HSV_STREAM_SAT_EN
        srem_q[k] <= srem_d[k];
        sden_q[k] <= sden_d[k];
        squo_q[k] <= squo_d[k];
`endif
        vld_q[k]  <= vld_d[k];
        tag_q[k]  <= tag_d[k];
        mx_q[k]   <= mx_d[k];
        neg_q[k]  <= neg_d[k];
        sec_q[k]  <= sec_d[k];
        hv_q[k]   <= hv_d[k];
      end
      hvld_q <= hvld_d;
      hhv_q  <= hhv_d;
      htag_q <= htag_d;
      hh_q   <= hh_d;
      hs_q   <= hs_d;
      hvv_q  <= hvv_d;
      ov_q   <= ov_d;
      ohv_q  <= ohv_d;
      otag_q <= otag_d;
      oh_q   <= oh_d;
      os_q   <= os_d;
      ovv_q  <= ovv_d;
    end
  end

  assign out_valid = ov_q;
  assign h         = oh_q;
  assign s         = os_q;
  assign v         = ovv_q;
  assign out_tag   = otag_q;
  assign hue_valid = ohv_q;

endmodule

// File: tb/tb_rgb2hsv_stream.sv
// Bench for rgb2hsv_stream: vector table plus model-driven random stream,
// checked against a scoreboard that also pins the arrival cycle.
module tb_rgb2hsv_stream;

  localparam int LAT = 12;

  typedef struct {
    logic [7:0] r, g, b;
    logic [1:0] tag;
    logic [7:0] h, s, v;
    logic       hv;
  } vec_t;

  typedef struct {
    logic [7:0] h, s, v;
    logic [1:0] tag;
    logic       hv;
    int         cyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic [1:0] in_tag = '0;
  logic       out_valid, hue_valid;
  logic [7:0] h, s, v;
  logic [1:0] out_tag;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sbq[$];
  exp_t last = '{8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 0};
  vec_t vt[12];

  rgb2hsv_stream #(.DW(8), .TW(2)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .r(r), .g(g), .b(b), .in_tag(in_tag),
    .out_valid(out_valid), .h(h), .s(s), .v(v),
    .out_tag(out_tag), .hue_valid(hue_valid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] sx(input logic [7:0] sv);
`ifdef RGB2HSV_STREAM_SAT_EN
    return sv;
`else
    return 8'd0;
`endif
  endfunction

  function automatic exp_t model(input int rr, gg, bb, input logic [1:0] t);
    exp_t e;
    int mx, mn, dl, d, off, q;
    mx = rr; if (gg > mx) mx = gg; if (bb > mx) mx = bb;
    mn = rr; if (gg < mn) mn = gg; if (bb < mn) mn = bb;
    dl = mx - mn;
    e.v = 8'(mx); e.tag = t; e.cyc = 0;
    if (dl == 0) begin
      e.h = 0; e.s = 0; e.hv = 0;
    end else begin
      if (rr == mx) begin d = gg - bb; off = 0; end
      else if (gg == mx) begin d = bb - rr; off = 85; end
      else begin d = rr - gg; off = 170; end
      q = (255 * (d < 0 ? -d : d)) / (6 * dl);
      e.h = 8'(d >= 0 ? off + q : off - q);
      e.s = sx(8'((255 * dl) / mx));
      e.hv = 1;
    end
    return e;
  endfunction

  task automatic drive(input logic vld, input logic [7:0] rr, gg, bb,
                       input logic [1:0] t, input exp_t e);
    @(posedge clock); #1;
    in_valid = vld; r = rr; g = gg; b = bb; in_tag = t;
    if (vld) begin
      e.cyc = cyc + 1 + LAT;
      sbq.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    exp_t z;
    z = '{8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 0};
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0, 8'd0, 8'd0, 2'd0, z);
  endtask

  task automatic check_zero(input string nm);
    n_cmp++;
    if (out_valid !== 1'b0 || hue_valid !== 1'b0 || h !== 8'd0 ||
        s !== 8'd0 || v !== 8'd0 || out_tag !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: got ov=%b hv=%b h=%0d s=%0d v=%0d tag=%0d, want all 0",
               nm, out_valid, hue_valid, h, s, v, out_tag);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      n_cmp++;
      if (out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out_valid at cycle %0d", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (h !== e.h || s !== e.s || v !== e.v || out_tag !== e.tag ||
              hue_valid !== e.hv || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL pixel: got h=%0d s=%0d v=%0d tag=%0d hv=%b cyc=%0d, want h=%0d s=%0d v=%0d tag=%0d hv=%b cyc=%0d",
                     h, s, v, out_tag, hue_valid, cyc,
                     e.h, e.s, e.v, e.tag, e.hv, e.cyc);
          end
          last = e;
        end
      end else if (out_valid !== 1'b0 || h !== last.h || s !== last.s ||
                   v !== last.v || out_tag !== last.tag ||
                   hue_valid !== last.hv) begin
        n_fail++;
        $display("FAIL hold at cycle %0d: got ov=%b h=%0d s=%0d v=%0d tag=%0d hv=%b, want ov=0 h=%0d s=%0d v=%0d tag=%0d hv=%b",
                 cyc, out_valid, h, s, v, out_tag, hue_valid,
                 last.h, last.s, last.v, last.tag, last.hv);
      end
    end
  end

  initial begin
    exp_t e;
    vt[0]  = '{8'd255, 8'd0,   8'd0,   2'd1, 8'd0,   8'd255, 8'd255, 1'b1};
    vt[1]  = '{8'd0,   8'd255, 8'd0,   2'd2, 8'd85,  8'd255, 8'd255, 1'b1};
    vt[2]  = '{8'd0,   8'd0,   8'd255, 2'd3, 8'd170, 8'd255, 8'd255, 1'b1};
    vt[3]  = '{8'd255, 8'd255, 8'd0,   2'd0, 8'd42,  8'd255, 8'd255, 1'b1};
    vt[4]  = '{8'd255, 8'd0,   8'd255, 2'd1, 8'd214, 8'd255, 8'd255, 1'b1};
    vt[5]  = '{8'd255, 8'd255, 8'd255, 2'd2, 8'd0,   8'd0,   8'd255, 1'b0};
    vt[6]  = '{8'd0,   8'd0,   8'd0,   2'd3, 8'd0,   8'd0,   8'd0,   1'b0};
    vt[7]  = '{8'd128, 8'd64,  8'd64,  2'd0, 8'd0,   8'd127, 8'd128, 1'b1};
    vt[8]  = '{8'd0,   8'd255, 8'd255, 2'd1, 8'd127, 8'd255, 8'd255, 1'b1};
    vt[9]  = '{8'd255, 8'd128, 8'd0,   2'd2, 8'd21,  8'd255, 8'd255, 1'b1};
    vt[10] = '{8'd10,  8'd20,  8'd30,  2'd3, 8'd149, 8'd170, 8'd30,  1'b1};
    vt[11] = '{8'd100, 8'd100, 8'd50,  2'd0, 8'd42,  8'd127, 8'd100, 1'b1};

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_zero("reset_state");

    for (int i = 0; i < 12; i++) begin
      e = '{vt[i].h, sx(vt[i].s), vt[i].v, vt[i].tag, vt[i].hv, 0};
      drive(1'b1, vt[i].r, vt[i].g, vt[i].b, vt[i].tag, e);
    end
    idle(20);

    begin
      logic [5:0] pat;
      pat = 6'b101101;
      for (int i = 0; i < 6; i++) begin
        e = model(40 * i, 200 - 20 * i, 90, 2'(i));
        drive(pat[5-i], 8'(40 * i), 8'(200 - 20 * i), 8'd90, 2'(i), e);
      end
    end
    idle(20);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] rr, gg, bb;
      logic [1:0] t;
      logic vl;
      rr = 8'($urandom_range(0, 255));
      gg = 8'($urandom_range(0, 255));
      bb = (i % 7 == 0) ? rr : 8'($urandom_range(0, 255));
      t  = 2'($urandom_range(0, 3));
      vl = $urandom_range(0, 3) != 0;
      e  = model(rr, gg, bb, t);
      drive(vl, rr, gg, bb, t, e);
    end
    idle(20);

    for (int i = 0; i < 5; i++) begin
      e = model(200, 10 * i, 5, 2'(i));
      drive(1'b1, 8'd200, 8'(10 * i), 8'd5, 2'(i), e);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    in_valid = 1'b0;
    sbq.delete();
    last = '{8'd0, 8'd0, 8'd0, 2'd0, 1'b0, 0};
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_zero("after_mid_reset");
    e = '{8'd0, sx(8'd255), 8'd255, 2'd1, 1'b1, 0};
    drive(1'b1, 8'd255, 8'd0, 8'd0, 2'd1, e);
    idle(25);

    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clock);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending pixels, want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb2hsv_stream.md
RGB2HSV_STREAM -- requirements
Module: rgb2hsv_stream

Interface
REQ-001 SHALL have parameter DW, default 8, meaning bits per colour component and per h/s/v output (legal 4..12).
REQ-002 SHALL have parameter TW, default 2, meaning the width of the sideband tag carried alongside each pixel (e.g. hsync/vsync).
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning r/g/b/in_tag are sampled this cycle.
REQ-006 SHALL have ports r, g, b, each input, DW, meaning unsigned colour components.
REQ-007 SHALL have port in_tag, input, TW, meaning sideband data that travels with the pixel unchanged.
REQ-008 SHALL have port out_valid, input-aligned result strobe, output, 1.
REQ-009 SHALL have ports h, s, v, each output, DW, meaning hue, saturation and value.
REQ-010 SHALL have port out_tag, output, TW, meaning in_tag of the pixel presented on h/s/v.
REQ-011 SHALL have port hue_valid, output, 1, meaning high when the pixel has a defined hue (delta > 0).

Function
REQ-012 SHALL be fully pipelined: one pixel accepted every cycle, no backpressure, no stalls.
REQ-013 SHALL have fixed latency LAT = DW+4 cycles from sampling in_valid to the matching out_valid (12 for DW=8).
REQ-014 Stage 1 SHALL register inputs. Stage 2 SHALL compute max, min and delta = max-min. Stage 3 SHALL form dividends and divisors. Stages 4..DW+3 SHALL run a restoring divider, one quotient bit per stage. Stage DW+4 SHALL form the hue.
REQ-015 SHALL define MAX = 2^DW-1. v SHALL equal max.
REQ-016 s SHALL equal floor(MAX*delta/max), and s SHALL be 0 when max = 0.
REQ-017 Sector selection SHALL use the first match in priority order r, g, b for the component equal to max. For r: d = g-b, offset 0. For g: d = b-r, offset OFF = floor(MAX/3). For b: d = r-g, offset 2*OFF.
REQ-018 The hue quotient SHALL be q = floor(MAX*|d|/(6*delta)), with q < 2^DW.
REQ-019 h SHALL equal (offset + q) mod 2^DW when d >= 0, and (offset - q) mod 2^DW when d < 0.
REQ-020 Intermediate products SHALL be 2*DW+3 bits wide, so no overflow occurs.
REQ-021 When delta = 0: h = 0, s = 0, and hue_valid = 0. Otherwise hue_valid = 1 with out_valid.
REQ-022 Valid, tag and sector/sign/offset sidebands SHALL shift in lockstep with the datapath.
REQ-023 Gaps in in_valid SHALL reappear unchanged in out_valid, delayed by LAT.
REQ-024 h, s, v, out_tag and hue_valid SHALL hold their last values while out_valid = 0.

Reset
REQ-025 While reset is high, out_valid, hue_valid, h, s, v and out_tag SHALL be 0 on the next edge, and every internal valid bit SHALL be cleared.
REQ-026 Pixels in flight when reset is asserted SHALL be discarded and never produce out_valid.
REQ-027 The first out_valid after reset release SHALL occur exactly LAT cycles after the first in_valid sampled with reset low.

Configuration
REQ-028 With macro RGB2HSV_STREAM_SAT_EN defined, the saturation divider SHALL be built and s SHALL behave per REQ-016.
REQ-029 With RGB2HSV_STREAM_SAT_EN undefined, the saturation divider SHALL be omitted and s SHALL be constant 0; h, v, LAT and all other behaviour SHALL be unchanged.

Verification (DW=8, TW=2, SAT_EN defined)
REQ-030 Input (255,0,0), tag 1 -> 12 cycles later: h=0, s=255, v=255, hue_valid=1, out_tag=1.
REQ-031 Inputs (0,255,0), (0,0,255), (255,255,0) and (255,0,255) on consecutive cycles -> h = 85, 170, 42 and 214 on consecutive cycles, with s=255 and v=255 for all.
REQ-032 Inputs (255,255,255) and (0,0,0) -> h=0, s=0, hue_valid=0, with v=255 and v=0 respectively. (128,64,64) -> h=0, s=127, v=128, hue_valid=1.
REQ-033 in_valid pattern 1,0,1,1,0,1 -> identical out_valid pattern starting at cycle 12, with tags preserved in order.
REQ-034 Reset asserted for 1 cycle with 5 pixels in flight -> no out_valid for those pixels, and all outputs 0 on the cycle after reset.
REQ-035 Rebuild without RGB2HSV_STREAM_SAT_EN and rerun REQ-030 -> s=0 and h/v unchanged.
